// File: rtl/button_input_port_if.sv
// rtl/button_input_port_if.sv - memory-stage read bus between the pipeline and the button port
interface button_input_port_if;
  logic        rdEn;
  logic [31:0] wb_Data;
  logic        MemDataSel;

  modport master (output rdEn, input wb_Data, input MemDataSel);
  modport slave  (input rdEn, output wb_Data, output MemDataSel);
endinterface

// File: rtl/button_input_port.sv
// rtl/button_input_port.sv - two debounced push-buttons with sticky press flags and a saturating press counter
module button_input_port #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                aclr,
  input  logic                PB1,
  input  logic                PB2,
  output logic                pb1Level,
  output logic                pb2Level,
  button_input_port_if.slave  bus
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI   = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO   = 2'd3;

  // Index 0 is PB1, index 1 is PB2 throughout.
  logic [1:0]         sync1_q,  sync1_d;
  logic [1:0]         sync2_q,  sync2_d;
  logic [1:0][1:0]    state_q,  state_d;
  logic [1:0][CW-1:0] cnt_q,    cnt_d;
  logic [1:0]         level_q,  level_d;
  logic [1:0]         sticky_q, sticky_d;
  logic [7:0]         count_q,  count_d;
  logic               mem_sel_q, mem_sel_d;

  logic [1:0] press_ev;
  logic [1:0] ev_cnt;
  logic [8:0] count_sum;

  always_comb begin
    sync1_d  = {PB2, PB1};
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = '0;
    press_ev = '0;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        STABLE_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = '0;
          end
        end
        WAIT_HI: begin
          if (!sync2_q[i])            state_d[i] = STABLE_LO;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = STABLE_HI;
          else                        cnt_d[i]   = cnt_q[i] + CW'(1);
        end
        STABLE_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = '0;
          end
        end
        WAIT_LO: begin
          if (sync2_q[i])             state_d[i] = STABLE_HI;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = STABLE_LO;
          else                        cnt_d[i]   = cnt_q[i] + CW'(1);
        end
        default: state_d[i] = STABLE_LO;
      endcase
      // An aborted release (WAIT_LO back to STABLE_HI) is not a new press.
      press_ev[i] = (state_q[i] == WAIT_HI) && (state_d[i] == STABLE_HI);
      level_d[i]  = (state_d[i] == STABLE_HI) || (state_d[i] == WAIT_LO);
    end
  end

  always_comb begin
    ev_cnt    = {1'b0, press_ev[0]} + {1'b0, press_ev[1]};
    count_sum = {1'b0, count_q} + {7'b0, ev_cnt};
    if (bus.rdEn) begin
      // Events landing on the read edge survive the clear.
      sticky_d = press_ev;
      count_d  = {6'b0, ev_cnt};
    end else begin
      sticky_d = sticky_q | press_ev;
      count_d  = count_sum[8] ? 8'hFF : count_sum[7:0];
    end
    mem_sel_d = |sticky_d;
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= {STABLE_LO, STABLE_LO};
      cnt_q     <= '0;
      level_q   <= '0;
      sticky_q  <= '0;
      count_q   <= '0;
      mem_sel_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  assign bus.wb_Data    = {16'h0000, count_q, 4'h0, sticky_q, level_q};
  assign bus.MemDataSel = mem_sel_q;
  assign pb1Level       = level_q[0];
  assign pb2Level       = level_q[1];

endmodule

// File: tb/tb_button_input_port.sv
// tb/tb_button_input_port.sv - directed self-checking bench for button_input_port with DEB_CYCLES=4
module tb_button_input_port;

  logic clock;
  logic aclr;
  logic PB1;
  logic PB2;
  logic pb1Level;
  logic pb2Level;
  int   tests;
  int   failed;

  button_input_port_if bus ();

  button_input_port #(.DEB_CYCLES(4)) dut (
    .clock    (clock),
    .aclr     (aclr),
    .PB1      (PB1),
    .PB2      (PB2),
    .pb1Level (pb1Level),
    .pb2Level (pb2Level),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_release_pb1();
    PB1 = 1'b1;
    tick(7);
    PB1 = 1'b0;
    tick(7);
  endtask

  task automatic do_read();
    bus.rdEn = 1'b1;
    tick(1);
    bus.rdEn = 1'b0;
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    aclr     = 1'b0;
    PB1      = 1'b0;
    PB2      = 1'b0;
    bus.rdEn = 1'b0;
    #1;
    check("reset_wb", bus.wb_Data, 32'h0);
    check("reset_sel", {31'b0, bus.MemDataSel}, 32'h0);
    check("reset_levels", {30'b0, pb2Level, pb1Level}, 32'h0);
    tick(3);
    aclr = 1'b1;
    tick(2);

    // Clean PB1 press: level appears after edge 6
    PB1 = 1'b1;
    tick(6);
    check("press_edge5_level", {31'b0, pb1Level}, 32'h0);
    tick(1);
    check("press_edge6_level", {31'b0, pb1Level}, 32'h1);
    check("press_wb", bus.wb_Data, 32'h0000_0105);
    check("press_sel", {31'b0, bus.MemDataSel}, 32'h1);

    do_read();
    check("read_wb", bus.wb_Data, 32'h0000_0001);
    check("read_sel", {31'b0, bus.MemDataSel}, 32'h0);

    do_read();
    check("idle_read_wb", bus.wb_Data, 32'h0000_0001);

    // Release: symmetric latency, no event
    PB1 = 1'b0;
    tick(6);
    check("release_edge5_level", {31'b0, pb1Level}, 32'h1);
    tick(1);
    check("release_edge6_level", {31'b0, pb1Level}, 32'h0);
    check("release_wb", bus.wb_Data, 32'h0);
    check("release_sel", {31'b0, bus.MemDataSel}, 32'h0);

    // PB2 glitch of 3 samples
    PB2 = 1'b1;
    tick(3);
    PB2 = 1'b0;
    tick(10);
    check("glitch_level", {31'b0, pb2Level}, 32'h0);
    check("glitch_wb", bus.wb_Data, 32'h0);
    check("glitch_sel", {31'b0, bus.MemDataSel}, 32'h0);

    // Three presses build count 3
    for (int k = 0; k < 3; k++) press_release_pb1();
    check("count3_wb", bus.wb_Data, 32'h0000_0304);

    // Fourth press event coincides with a read
    PB1 = 1'b1;
    tick(6);
    bus.rdEn = 1'b1;
    tick(1);
    bus.rdEn = 1'b0;
    check("collision_wb", bus.wb_Data, 32'h0000_0105);
    check("collision_sel", {31'b0, bus.MemDataSel}, 32'h1);
    PB1 = 1'b0;
    tick(7);

    do_read();
    check("clear_wb", bus.wb_Data, 32'h0);

    // Both buttons press on the same edge
    PB1 = 1'b1;
    PB2 = 1'b1;
    tick(7);
    check("both_wb", bus.wb_Data, 32'h0000_020F);
    PB1 = 1'b0;
    PB2 = 1'b0;
    tick(7);
    check("both_release_wb", bus.wb_Data, 32'h0000_020C);

    // Saturation
    for (int k = 0; k < 300; k++) press_release_pb1();
    check("saturate_wb", bus.wb_Data, 32'h0000_FF0C);
    check("saturate_sel", {31'b0, bus.MemDataSel}, 32'h1);

    do_read();
    check("sat_clear_wb", bus.wb_Data, 32'h0);

    // Reset in the middle of a debounce
    PB1 = 1'b1;
    tick(4);
    aclr = 1'b0;
    #1;
    check("midrst_wb", bus.wb_Data, 32'h0);
    check("midrst_levels", {30'b0, pb2Level, pb1Level}, 32'h0);
    tick(2);
    check("midrst_hold_wb", bus.wb_Data, 32'h0);
    check("midrst_hold_sel", {31'b0, bus.MemDataSel}, 32'h0);
    aclr = 1'b1;
    tick(6);
    check("midrst_edge5_wb", bus.wb_Data, 32'h0);
    tick(1);
    check("midrst_edge6_wb", bus.wb_Data, 32'h0000_0105);
    check("midrst_edge6_sel", {31'b0, bus.MemDataSel}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
